mem_bus_arbiter: RTL and testbench

//  Shares the single 16-bit-address memory bus between instruction fetch (port 0, read-only) and

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_region_decode.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for mem_bus_arbiter and its address decoder
package bus_pkg;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_IO,
    REGION_NONE
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bus_state_e;

  // Highest address page (addr[15:8]) that maps to RAM
  localparam logic [7:0] RAM_PAGE_MAX = 8'h01;
  // Single address page that maps to the peripheral block
  localparam logic [7:0] IO_PAGE      = 8'h02;

  // Port identifiers, also the encoding of the round-robin "last winner" bit
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/bus_region_decode.sv
// rtl/bus_region_decode.sv - combinational address page decode to RAM / IO / unmapped plus word-alignment flag
module bus_region_decode
  import bus_pkg::*;
(
  input  logic [7:0] page_i,
  input  logic [1:0] offset_i,
  output region_e    region_o,
  output logic       misalign_o
);

  // Page map: low pages are RAM, one IO page, everything above is unmapped
  always_comb begin
    region_o = REGION_NONE;
    if (page_i <= RAM_PAGE_MAX) begin
      region_o = REGION_RAM;
    end else if (page_i == IO_PAGE) begin
      region_o = REGION_IO;
    end
  end

  // Only whole 32-bit words are addressable on this bus
  assign misalign_o = (offset_i != 2'b00);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/LSU memory bus arbiter and sequencer; define BUS_TIMEOUT_EN to abort stalled accesses
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [15:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic        ls_err,
  output logic [31:0] rsp_rdata,
  output logic [15:0] m_addr,
  output logic        m_we,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        ram_sel,
  output logic        io_sel,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  input  logic        io_ready,
  input  logic [31:0] io_rdata
);

  bus_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_last_q, rr_last_d;
  logic [15:0] m_addr_q, m_addr_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  region_e     region_q, region_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        any_req;
  logic        ls_win;
  logic        if_win;
  logic [15:0] win_addr;
  region_e     dec_region;
  logic        dec_misalign;
  logic        target_ready;
  logic        timeout_hit;
  logic        access_done;

  // Arbitration: on conflict the port that did not win last time goes first
  assign any_req  = if_req | ls_req;
  assign ls_win   = ls_req && (!if_req || (rr_last_q == PORT_IF));
  assign if_win   = if_req && !ls_win;
  assign win_addr = ls_win ? ls_addr : if_addr;

  bus_region_decode u_decode (
    .page_i     (win_addr[15:8]),
    .offset_i   (win_addr[1:0]),
    .region_o   (dec_region),
    .misalign_o (dec_misalign)
  );

  // Only the target that was decoded for this transaction can complete it
  assign target_ready = ((region_q == REGION_RAM) && ram_ready) ||
                        ((region_q == REGION_IO)  && io_ready);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Abort on the last allowed ACCESS cycle; a ready in that same cycle still wins
  assign timeout_hit = (state_q == ST_ACCESS) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // ACCESS cycle counter, cleared when a transaction is granted
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = 8'd0;
    end else if (state_q == ST_ACCESS) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Decode errors finish after one ACCESS cycle; otherwise wait for ready (or timeout)
  assign access_done = (region_q == REGION_NONE) || target_ready || timeout_hit;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one transaction in flight, IDLE -> ACCESS -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: if (access_done) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grants only in IDLE, selects only in ACCESS, response strobe only in RESP
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    ram_sel   = 1'b0;
    io_sel    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    if_err    = 1'b0;
    ls_err    = 1'b0;
    rsp_rdata = 32'd0;
    case (state_q)
      ST_IDLE: begin
        // Grants are combinational from req, so mask them while reset is held
        if_gnt = rst_n && if_win;
        ls_gnt = rst_n && ls_win;
      end
      ST_ACCESS: begin
        ram_sel = (region_q == REGION_RAM);
        io_sel  = (region_q == REGION_IO);
      end
      ST_RESP: begin
        rsp_rdata = rdata_q;
        if (owner_q == PORT_LS) begin
          ls_rvalid = 1'b1;
          ls_err    = rsp_err_q;
        end else begin
          if_rvalid = 1'b1;
          if_err    = rsp_err_q;
        end
      end
      default: ;
    endcase
  end

  // Transaction capture at grant and response capture at end of ACCESS
  always_comb begin
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    m_addr_d  = m_addr_q;
    m_we_d    = m_we_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    region_d  = region_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    if ((state_q == ST_IDLE) && any_req) begin
      owner_d   = ls_win;
      rr_last_d = ls_win;
      m_addr_d  = win_addr;
      m_we_d    = ls_win && ls_we;
      m_wdata_d = ls_win ? ls_wdata : 32'd0;
      m_wstrb_d = (ls_win && ls_we) ? ls_wstrb : 4'b0000;
      // Misaligned or unmapped addresses never reach a target
      region_d  = (dec_misalign || (dec_region == REGION_NONE)) ? REGION_NONE : dec_region;
    end
    if ((state_q == ST_ACCESS) && access_done) begin
      if (target_ready) begin
        rsp_err_d = 1'b0;
        rdata_d   = m_we_q ? 32'd0 :
                    ((region_q == REGION_RAM) ? ram_rdata : io_rdata);
      end else begin
        rsp_err_d = 1'b1;
        rdata_d   = 32'd0;
      end
    end
  end

  // Transaction registers; fetch wins the first conflict after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= PORT_IF;
      rr_last_q <= PORT_LS;
      m_addr_q  <= 16'd0;
      m_we_q    <= 1'b0;
      m_wdata_q <= 32'd0;
      m_wstrb_q <= 4'b0000;
      region_q  <= REGION_NONE;
      rdata_q   <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      m_addr_q  <= m_addr_d;
      m_we_q    <= m_we_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      region_q  <= region_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_we    = m_we_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'd0;
  logic        if_gnt, if_rvalid, if_err;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = 16'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic [3:0]  ls_wstrb = 4'd0;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] rsp_rdata;
  logic [15:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        ram_sel, io_sel;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_rdata = 32'h1111_0000;
  logic        io_ready = 1'b0;
  logic [31:0] io_rdata = 32'h2222_0000;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_err(ls_err), .rsp_rdata(rsp_rdata),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .ram_sel(ram_sel), .io_sel(io_sel),
    .ram_ready(ram_ready), .ram_rdata(ram_rdata), .io_ready(io_ready), .io_rdata(io_rdata)
  );

  // ---------------- behavioural model (transaction level) ----------------
  typedef struct {
    logic        owner;   // 1 = load/store
    logic [15:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          tgt;     // 0 RAM, 1 IO, 2 decode error
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t md_t;
  int   md_phase;         // 0 free, 1 target being accessed, 2 response due
  logic md_rr;            // last winner was load/store
  int   md_wait;

  function automatic int tgt_of(input logic [15:0] a);
    if ((a % 4) != 0 || (a / 256) > 2) return 2;
    if ((a / 256) == 2) return 1;
    return 0;
  endfunction

  logic md_ls_wins;
  assign md_ls_wins = ls_req && !(if_req && md_rr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_phase <= 0;
      md_rr    <= 1'b1;
      md_wait  <= 0;
      md_t     <= '{default: 0};
    end else begin
      case (md_phase)
        0: if (if_req || ls_req) begin
          md_t.owner <= md_ls_wins;
          md_t.addr  <= md_ls_wins ? ls_addr : if_addr;
          md_t.we    <= md_ls_wins && ls_we;
          md_t.wdata <= md_ls_wins ? ls_wdata : 32'd0;
          md_t.wstrb <= (md_ls_wins && ls_we) ? ls_wstrb : 4'd0;
          md_t.tgt   <= tgt_of(md_ls_wins ? ls_addr : if_addr);
          md_rr      <= md_ls_wins;
          md_wait    <= 0;
          md_phase   <= 1;
        end
        1: begin
          md_wait <= md_wait + 1;
          if (md_t.tgt == 2) begin
            md_t.err <= 1'b1; md_t.rdata <= 32'd0; md_phase <= 2;
          end else if ((md_t.tgt == 0 && ram_ready) || (md_t.tgt == 1 && io_ready)) begin
            md_t.err   <= 1'b0;
            md_t.rdata <= md_t.we ? 32'd0 : ((md_t.tgt == 0) ? ram_rdata : io_rdata);
            md_phase   <= 2;
          end
`ifdef BUS_TIMEOUT_EN
          else if (md_wait + 1 == 4) begin
            md_t.err <= 1'b1; md_t.rdata <= 32'd0; md_phase <= 2;
          end
`endif
        end
        default: md_phase <= 0;
      endcase
    end
  end

  // ---------------- checking ----------------
  int errs = 0;
  int checks = 0;
  int ncyc = 0;

  string       lit_nm [128];
  logic [31:0] lit_act[128];
  logic [31:0] lit_exp[128];
  int          lit_wr = 0;
  int          lit_rd = 0;

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_nm[lit_wr]  = nm;
    lit_act[lit_wr] = act;
    lit_exp[lit_wr] = exp;
    lit_wr = lit_wr + 1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errs = errs + 1;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, ncyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e_if_gnt, e_ls_gnt, in_resp;
    while (lit_rd < lit_wr) begin
      chk(lit_nm[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd = lit_rd + 1;
    end
    e_if_gnt = rst_n && md_phase == 0 && if_req && !md_ls_wins;
    e_ls_gnt = rst_n && md_phase == 0 && md_ls_wins;
    in_resp  = (md_phase == 2);
    chk("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
    chk("ls_gnt",    32'(ls_gnt),    32'(e_ls_gnt));
    chk("ram_sel",   32'(ram_sel),   32'(md_phase == 1 && md_t.tgt == 0));
    chk("io_sel",    32'(io_sel),    32'(md_phase == 1 && md_t.tgt == 1));
    chk("if_rvalid", 32'(if_rvalid), 32'(in_resp && !md_t.owner));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(in_resp && md_t.owner));
    chk("if_err",    32'(if_err),    32'(in_resp && !md_t.owner && md_t.err));
    chk("ls_err",    32'(ls_err),    32'(in_resp && md_t.owner && md_t.err));
    chk("rsp_rdata", rsp_rdata,      in_resp ? md_t.rdata : 32'd0);
    chk("m_cmd",     {11'd0, m_we, m_wstrb, m_addr}, {11'd0, md_t.we, md_t.wstrb, md_t.addr});
    chk("m_wdata",   m_wdata,        md_t.wdata);
  end

  // ---------------- stimulus ----------------
  logic s_if_gnt, s_ls_gnt, s_ram_sel, s_io_sel, s_if_rv, s_ls_rv, s_if_err, s_ls_err;
  logic [31:0] s_rdata;
  bit hold_req = 1'b0;
  int ram_lat = 1, io_lat = 1, ram_cnt = 0, io_cnt = 0;

  // One clock: sample outputs mid-cycle, then update requests and target responders after the edge
  task automatic cyc();
    @(negedge clk);
    s_if_gnt = if_gnt; s_ls_gnt = ls_gnt; s_ram_sel = ram_sel; s_io_sel = io_sel;
    s_if_rv = if_rvalid; s_ls_rv = ls_rvalid; s_if_err = if_err; s_ls_err = ls_err;
    s_rdata = rsp_rdata;
    @(posedge clk);
    #1;
    if (s_if_gnt && !hold_req) if_req = 1'b0;
    if (s_ls_gnt && !hold_req) ls_req = 1'b0;
    ram_cnt   = ram_sel ? ram_cnt + 1 : 0;
    io_cnt    = io_sel ? io_cnt + 1 : 0;
    ram_ready = ram_sel && ram_lat != 0 && ram_cnt == ram_lat;
    io_ready  = io_sel && io_lat != 0 && io_cnt == io_lat;
    ncyc = ncyc + 1;
  endtask

  task automatic run_txn(input logic port, input logic we, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         output int gnt_c, output int sel_first, output int sel_n,
                         output int rv_c, output logic err, output logic [31:0] rdata);
    gnt_c = -1; sel_first = -1; sel_n = 0; rv_c = -1; err = 1'bx; rdata = 'x;
    if (port) begin
      ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_wstrb = wstrb; ls_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    for (int k = 0; k < 40 && rv_c < 0; k++) begin
      cyc();
      if ((port ? s_ls_gnt : s_if_gnt) && gnt_c < 0) gnt_c = k;
      if (s_ram_sel || s_io_sel) begin
        if (sel_first < 0) sel_first = k;
        sel_n = sel_n + 1;
      end
      if (port ? s_ls_rv : s_if_rv) begin
        rv_c = k; err = port ? s_ls_err : s_if_err; rdata = s_rdata;
      end
    end
    if (rv_c < 0) lit("txn_response_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_both(input int n, output int ports[4], output int cycs[4]);
    int got;
    got = 0;
    hold_req = 1'b1;
    if_addr = 16'h0100; ls_addr = 16'h0020; ls_we = 1'b0; ram_lat = 1;
    if_req = 1'b1; ls_req = 1'b1;
    for (int k = 0; k < 60 && got < n; k++) begin
      cyc();
      if (s_if_gnt || s_ls_gnt) begin
        ports[got] = s_ls_gnt ? 1 : 0; cycs[got] = k; got = got + 1;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; hold_req = 1'b0;
    if (got < n) lit("grant_timeout", 32'(got), 32'(n));
    repeat (4) cyc();
  endtask

  initial begin
    int g, sf, sn, rv;
    logic e;
    logic [31:0] rd;
    int ps[4], cs[4];

    // Reset held with both requests up: every output must stay at zero
    if_req = 1'b1; ls_req = 1'b1; if_addr = 16'h0010; ls_addr = 16'h0204;
    repeat (2) @(posedge clk);
    #1;
    lit("rst_flags", {24'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, ram_sel, io_sel}, 32'd0);
    lit("rst_m_addr", {16'd0, m_addr}, 32'd0);
    lit("rst_rdata", rsp_rdata | m_wdata, 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous requests from both ports: fetch first, then strict alternation every 3 cycles
    run_both(4, ps, cs);
    for (int i = 0; i < 4; i++) begin
      lit("alt_port", 32'(ps[i]), 32'(i % 2));
      lit("alt_cycle", 32'(cs[i]), 32'(3 * i));
    end

    // Fetch from RAM, ready in the first select cycle
    ram_rdata = 32'hDEADBEEF; ram_lat = 1;
    run_txn(1'b0, 1'b0, 16'h0010, 32'd0, 4'd0, g, sf, sn, rv, e, rd);
    lit("f_gnt_c", 32'(g), 32'd0);
    lit("f_sel_c", 32'(sf), 32'd1);
    lit("f_sel_n", 32'(sn), 32'd1);
    lit("f_rv_c", 32'(rv), 32'd2);
    lit("f_err", 32'(e), 32'd0);
    lit("f_rdata", rd, 32'hDEADBEEF);

    // IO write with a 3-cycle target stall
    io_lat = 3; io_rdata = 32'hA5A5A5A5;
    run_txn(1'b1, 1'b1, 16'h0204, 32'h12345678, 4'b0011, g, sf, sn, rv, e, rd);
    lit("w_gnt_c", 32'(g), 32'd0);
    lit("w_sel_c", 32'(sf), 32'd1);
    lit("w_sel_n", 32'(sn), 32'd3);
    lit("w_rv_c", 32'(rv), 32'd4);
    lit("w_err", 32'(e), 32'd0);
    lit("w_rdata", rd, 32'd0);

    // Unmapped page, then misaligned RAM address: no select, error at gnt+2
    run_txn(1'b1, 1'b0, 16'h0300, 32'd0, 4'd0, g, sf, sn, rv, e, rd);
    lit("um_sel_n", 32'(sn), 32'd0);
    lit("um_rv_c", 32'(rv - g), 32'd2);
    lit("um_err_rdata", {31'd0, e} | rd, 32'd1);
    run_txn(1'b1, 1'b0, 16'h0002, 32'd0, 4'd0, g, sf, sn, rv, e, rd);
    lit("mis_sel_n", 32'(sn), 32'd0);
    lit("mis_rv_c", 32'(rv - g), 32'd2);
    lit("mis_err_rdata", {31'd0, e} | rd, 32'd1);

    // IO read, 2-cycle stall
    io_lat = 2;
    run_txn(1'b1, 1'b0, 16'h0208, 32'hFFFF0000, 4'hF, g, sf, sn, rv, e, rd);
    lit("ior_sel_n", 32'(sn), 32'd2);
    lit("ior_rv_c", 32'(rv), 32'd3);
    lit("ior_rdata", rd, 32'hA5A5A5A5);

    // Reset while IO is selected and stalled
    io_lat = 0;
    ls_we = 1'b0; ls_addr = 16'h020C; ls_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (s_io_sel) break;
    end
    lit("pre_rst_io_sel", 32'(s_io_sel), 32'd1);
    cyc();
    ls_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    lit("arst_flags", {24'd0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err, ram_sel, io_sel}, 32'd0);
    lit("arst_m", {m_addr, 11'd0, m_we, m_wstrb} | m_wdata | rsp_rdata, 32'd0);
    ls_req = 1'b0;
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_both(2, ps, cs);
    lit("post_rst_first", 32'(ps[0]), 32'd0);
    lit("post_rst_second", 32'(ps[1]), 32'd1);

`ifdef BUS_TIMEOUT_EN
    // RAM never ready: abort after 4 select cycles
    ram_lat = 0;
    run_txn(1'b0, 1'b0, 16'h0040, 32'd0, 4'd0, g, sf, sn, rv, e, rd);
    lit("to_sel_n", 32'(sn), 32'd4);
    lit("to_rv_c", 32'(rv), 32'd5);
    lit("to_err", 32'(e), 32'd1);
    lit("to_rdata", rd, 32'd0);
    // Ready on the final allowed cycle completes normally
    ram_lat = 4; ram_rdata = 32'h0BADF00D;
    run_txn(1'b0, 1'b0, 16'h0040, 32'd0, 4'd0, g, sf, sn, rv, e, rd);
    lit("edge_sel_n", 32'(sn), 32'd4);
    lit("edge_rv_c", 32'(rv), 32'd5);
    lit("edge_err", 32'(e), 32'd0);
    lit("edge_rdata", rd, 32'h0BADF00D);
`endif

    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
